// File: rtl/lacc_mem_bridge.sv
// lacc_mem_bridge: registers CNN accelerator data requests, issues them on a req/gnt SRAM bus and
// returns size-aligned read data in order. Define LACC_BRIDGE_CHK_EN to build the sticky err checks.
module lacc_mem_bridge #(
   parameter int OUTSTANDING = 4,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lacc_flush,
   input  logic              lacc_data_valid,
   output logic              lacc_data_ready,
   input  logic [ADDR_W-1:0] lacc_data_addr,
   input  logic              lacc_data_read,
   input  logic [31:0]       lacc_data_wdata,
   input  logic [1:0]        lacc_data_size,
   output logic              lacc_drsp_valid,
   output logic [31:0]       lacc_drsp_rdata,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata,
   output logic              idle,
   output logic              err
);

   localparam int PW = $clog2(OUTSTANDING);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] OUT_C = CW'(OUTSTANDING);

   function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lanes_of(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] res;
      case (size)
         2'b00:   res = {4{wdata[7:0]}};
         2'b01:   res = {2{wdata[15:0]}};
         default: res = wdata;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] align_of(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] rdata);
      logic [31:0] res;
      case (size)
         2'b00:   res = {24'h000000, rdata[{off, 3'b000} +: 8]};
         2'b01:   res = {16'h0000, rdata[{off[1], 4'b0000} +: 16]};
         default: res = rdata;
      endcase
      return res;
   endfunction

   logic              slot_v_q, slot_v_d;
   logic              slot_read_q, slot_read_d;
   logic [1:0]        slot_size_q, slot_size_d;
   logic [1:0]        slot_off_q, slot_off_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     rcnt_q, rcnt_d;
   logic [CW-1:0]     drop_q, drop_d;
   logic [3:0]        fifo_q [OUTSTANDING];
   logic              rsp_v_q, rsp_v_d;
   logic [31:0]       rsp_data_q, rsp_data_d;

   logic              accept_s, issue_s, push_s, pop_s, fifo_empty_s;
   logic [3:0]        head_s;

   assign bus_req         = slot_v_q & (~slot_read_q | (rcnt_q < OUT_C));
   assign issue_s         = bus_req & bus_gnt;
   assign lacc_data_ready = ~slot_v_q | issue_s;
   assign accept_s        = lacc_data_valid & lacc_data_ready;
   assign fifo_empty_s    = (wr_ptr_q == rd_ptr_q);
   assign push_s          = issue_s & slot_read_q;
   assign pop_s           = bus_rvalid & ~fifo_empty_s;
   assign head_s          = fifo_q[rd_ptr_q[PW-1:0]];

   assign bus_we          = we_q;
   assign bus_addr        = addr_q;
   assign bus_be          = be_q;
   assign bus_wdata       = wdata_q;
   assign lacc_drsp_valid = rsp_v_q;
   assign lacc_drsp_rdata = rsp_data_q;
   assign idle            = ~slot_v_q & (rcnt_q == {CW{1'b0}});

   // Request slot: bus fields are prepared at accept and held until the grant.
   always_comb begin
      slot_v_d    = slot_v_q;
      slot_read_d = slot_read_q;
      slot_size_d = slot_size_q;
      slot_off_d  = slot_off_q;
      we_d        = we_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      if (accept_s) begin
         slot_v_d    = 1'b1;
         slot_read_d = lacc_data_read;
         slot_size_d = lacc_data_size;
         slot_off_d  = lacc_data_addr[1:0];
         we_d        = ~lacc_data_read;
         addr_d      = {lacc_data_addr[ADDR_W-1:2], 2'b00};
         be_d        = be_of(lacc_data_size, lacc_data_addr[1:0]);
         wdata_d     = lanes_of(lacc_data_size, lacc_data_wdata);
      end else if (issue_s || lacc_flush) begin
         slot_v_d = 1'b0;
      end else begin
         slot_v_d = slot_v_q;
      end
   end

   // Read tracking, flush drain count and registered response.
   always_comb begin
      wr_ptr_d   = push_s ? wr_ptr_q + CW'(1) : wr_ptr_q;
      rd_ptr_d   = pop_s ? rd_ptr_q + CW'(1) : rd_ptr_q;
      rcnt_d     = rcnt_q;
      drop_d     = drop_q;
      rsp_v_d    = 1'b0;
      rsp_data_d = rsp_data_q;
      case ({push_s, pop_s})
         2'b10:   rcnt_d = rcnt_q + CW'(1);
         2'b01:   rcnt_d = rcnt_q - CW'(1);
         default: rcnt_d = rcnt_q;
      endcase
      if (lacc_flush) begin
         drop_d = rcnt_d;
      end else if (pop_s && (drop_q != {CW{1'b0}})) begin
         drop_d = drop_q - CW'(1);
      end else begin
         drop_d = drop_q;
      end
      if (pop_s && !lacc_flush && (drop_q == {CW{1'b0}})) begin
         rsp_v_d    = 1'b1;
         rsp_data_d = align_of(head_s[3:2], head_s[1:0], bus_rdata);
      end else begin
         rsp_v_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_v_q    <= 1'b0;
         slot_read_q <= 1'b0;
         slot_size_q <= 2'b00;
         slot_off_q  <= 2'b00;
         we_q        <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         be_q        <= 4'h0;
         wdata_q     <= 32'h0000_0000;
         wr_ptr_q    <= {CW{1'b0}};
         rd_ptr_q    <= {CW{1'b0}};
         rcnt_q      <= {CW{1'b0}};
         drop_q      <= {CW{1'b0}};
         rsp_v_q     <= 1'b0;
         rsp_data_q  <= 32'h0000_0000;
         for (int i = 0; i < OUTSTANDING; i++) begin
            fifo_q[i] <= 4'h0;
         end
      end else begin
         slot_v_q    <= slot_v_d;
         slot_read_q <= slot_read_d;
         slot_size_q <= slot_size_d;
         slot_off_q  <= slot_off_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rcnt_q      <= rcnt_d;
         drop_q      <= drop_d;
         rsp_v_q     <= rsp_v_d;
         rsp_data_q  <= rsp_data_d;
         if (push_s) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= {slot_size_q, slot_off_q};
         end
      end
   end

`ifdef LACC_BRIDGE_CHK_EN
   logic err_q, err_d, misalign_s;

   // Sticky error: misaligned or reserved-size accept, or rvalid with nothing outstanding.
   always_comb begin
      misalign_s = 1'b0;
      case (lacc_data_size)
         2'b01:   misalign_s = lacc_data_addr[0];
         2'b10:   misalign_s = |lacc_data_addr[1:0];
         2'b11:   misalign_s = 1'b1;
         default: misalign_s = 1'b0;
      endcase
      if ((accept_s && misalign_s) || (bus_rvalid && fifo_empty_s)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lacc_mem_bridge.sv
// Self-checking bench for lacc_mem_bridge: directed scenarios plus random traffic against a
// transaction-level model (slot queue, in-flight read queue with drop marks).
module tb_lacc_mem_bridge;

   localparam int OUT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        lacc_flush = 1'b0;
   logic        lacc_data_valid = 1'b0;
   logic        lacc_data_ready;
   logic [31:0] lacc_data_addr = 32'h0;
   logic        lacc_data_read = 1'b0;
   logic [31:0] lacc_data_wdata = 32'h0;
   logic [1:0]  lacc_data_size = 2'b00;
   logic        lacc_drsp_valid;
   logic [31:0] lacc_drsp_rdata;
   logic        bus_req;
   logic        bus_gnt = 1'b0;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        idle;
   logic        err;

   lacc_mem_bridge #(.OUTSTANDING(OUT), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .lacc_flush(lacc_flush),
      .lacc_data_valid(lacc_data_valid), .lacc_data_ready(lacc_data_ready),
      .lacc_data_addr(lacc_data_addr), .lacc_data_read(lacc_data_read),
      .lacc_data_wdata(lacc_data_wdata), .lacc_data_size(lacc_data_size),
      .lacc_drsp_valid(lacc_drsp_valid), .lacc_drsp_rdata(lacc_drsp_rdata),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .idle(idle), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; bit rd; logic [31:0] wdata; int sz; } req_t;
   typedef struct { int sz; int off; bit drop; } rd_t;

   req_t        slot_m[$];
   rd_t         pend_m[$];
   bit          exp_v_nx = 1'b0;
   logic [31:0] exp_d_nx = 32'h0;
   bit          exp_err = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic int eff_sz(input int sz);
      return (sz == 3) ? 2 : sz;
   endfunction

   function automatic logic [31:0] m_be(input req_t r);
      int o = int'(r.addr % 4);
      case (eff_sz(r.sz))
         0:       return 32'(1 << o);
         1:       return 32'(3 << (2 * (o / 2)));
         default: return 32'd15;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input req_t r);
      case (eff_sz(r.sz))
         0:       return (r.wdata % 256) * 32'h0101_0101;
         1:       return (r.wdata % 65536) * 32'h0001_0001;
         default: return r.wdata;
      endcase
   endfunction

   function automatic logic [31:0] m_rdata(input rd_t p, input logic [31:0] r);
      case (eff_sz(p.sz))
         0:       return (r >> (8 * p.off)) % 256;
         1:       return (r >> (16 * (p.off / 2))) % 65536;
         default: return r;
      endcase
   endfunction

   // One clock cycle: drive inputs, check DUT against the model mid-cycle, advance the model.
   task automatic cycle(input bit v, input logic [31:0] a, input bit rd, input logic [31:0] wd,
                        input int sz, input bit gnt, input bit fl, input bit rv,
                        input logic [31:0] rdat, output bit acc);
      bit   exp_req, exp_rdy, iss, rv_eff;
      req_t h;
      rd_t  p;
      rv_eff          = rv && (pend_m.size() > 0);
      lacc_data_valid = v;
      lacc_data_addr  = a;
      lacc_data_read  = rd;
      lacc_data_wdata = wd;
      lacc_data_size  = 2'(sz);
      bus_gnt         = gnt;
      lacc_flush      = fl;
      bus_rvalid      = rv_eff;
      bus_rdata       = rdat;
      @(negedge clk);
      chk("drsp_valid", {31'h0, lacc_drsp_valid}, {31'h0, exp_v_nx});
      if (exp_v_nx) chk("drsp_rdata", lacc_drsp_rdata, exp_d_nx);
      exp_v_nx = 1'b0;
      chk("err", {31'h0, err}, {31'h0, exp_err});
      chk("idle", {31'h0, idle}, {31'h0, (slot_m.size() == 0 && pend_m.size() == 0)});
      exp_req = (slot_m.size() != 0) && (!slot_m[0].rd || pend_m.size() < OUT);
      chk("bus_req", {31'h0, bus_req}, {31'h0, exp_req});
      if (exp_req) begin
         chk("bus_addr", bus_addr, slot_m[0].addr & 32'hFFFF_FFFC);
         chk("bus_be", {28'h0, bus_be}, m_be(slot_m[0]));
         chk("bus_we", {31'h0, bus_we}, {31'h0, !slot_m[0].rd});
         if (!slot_m[0].rd) chk("bus_wdata", bus_wdata, m_wdata(slot_m[0]));
      end
      iss     = exp_req && gnt;
      exp_rdy = (slot_m.size() == 0) || iss;
      chk("ready", {31'h0, lacc_data_ready}, {31'h0, exp_rdy});
      if (fl) foreach (pend_m[i]) pend_m[i].drop = 1'b1;
      if (rv_eff) begin
         p = pend_m.pop_front();
         if (!p.drop) begin
            exp_v_nx = 1'b1;
            exp_d_nx = m_rdata(p, rdat);
         end
      end
      if (iss) begin
         h = slot_m.pop_front();
         if (h.rd) pend_m.push_back('{sz: h.sz, off: int'(h.addr % 4), drop: fl});
      end else if (fl) begin
         slot_m.delete();
      end
      acc = v && exp_rdy;
      if (acc) begin
         slot_m.push_back('{addr: a, rd: rd, wdata: wd, sz: sz});
`ifdef LACC_BRIDGE_CHK_EN
         if (sz == 3 || (sz == 1 && a[0]) || (sz == 2 && (a % 4) != 0)) exp_err = 1'b1;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc(input int n, input bit gnt);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 0, gnt, 1'b0, 1'b0, 32'h0, acc);
   endtask

   task automatic send(input logic [31:0] a, input bit rd, input logic [31:0] wd, input int sz);
      bit acc;
      int k;
      acc = 1'b0;
      for (k = 0; k < 20 && !acc; k++) cycle(1'b1, a, rd, wd, sz, 1'b1, 1'b0, 1'b0, 32'h0, acc);
      if (!acc) chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain();
      bit acc;
      int k;
      for (k = 0; k < 300 && (slot_m.size() != 0 || pend_m.size() != 0); k++)
         cycle(1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 1'b1, $urandom, acc);
      if (slot_m.size() != 0 || pend_m.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
      idle_cyc(1, 1'b1);
   endtask

   initial begin
      bit acc;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'h0, lacc_data_ready}, 32'd1);
      chk("rst_idle", {31'h0, idle}, 32'd1);
      chk("rst_req", {31'h0, bus_req}, 32'd0);
      chk("rst_we", {31'h0, bus_we}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_be", {28'h0, bus_be}, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_drsp_v", {31'h0, lacc_drsp_valid}, 32'd0);
      chk("rst_drsp_d", lacc_drsp_rdata, 32'd0);
      chk("rst_err", {31'h0, err}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Word read at 0x100, response three cycles after issue.
      send(32'h100, 1'b1, 32'h0, 2);
      idle_cyc(3, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, acc);
      idle_cyc(1, 1'b1);

      // Byte read at 0x203 and half read at 0x202 against 0xAABBCCDD.
      send(32'h203, 1'b1, 32'h0, 0);
      idle_cyc(1, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 1'b1, 32'hAABB_CCDD, acc);
      chk("byte_rdata", exp_d_nx, 32'h0000_00AA);
      idle_cyc(1, 1'b1);
      send(32'h202, 1'b1, 32'h0, 1);
      idle_cyc(1, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 1'b1, 32'hAABB_CCDD, acc);
      idle_cyc(1, 1'b1);

      // Half write 0x1234 at 0x12, with a slow grant.
      send(32'h12, 1'b0, 32'h1234, 1);
      idle_cyc(2, 1'b0);
      chk("hw_be", {28'h0, bus_be}, 32'h0000_000C);
      chk("hw_wdata", bus_wdata, 32'h1234_1234);
      idle_cyc(2, 1'b1);

      // Outstanding limit: five reads, the fifth waits in the slot.
      for (int i = 0; i < 5; i++) send(32'h400 + 32'(4 * i), 1'b1, 32'h0, 2);
      idle_cyc(2, 1'b1);
      chk("limit_req", {31'h0, bus_req}, 32'd0);
      chk("limit_rdy", {31'h0, lacc_data_ready}, 32'd0);
      cycle(1'b1, 32'h414, 1'b1, 32'h0, 2, 1'b1, 1'b0, 1'b1, 32'h1111_0001, acc);
      for (int k = 0; k < 10 && !acc; k++)
         cycle(1'b1, 32'h414, 1'b1, 32'h0, 2, 1'b1, 1'b0, 1'b0, 32'h0, acc);
      drain();

      // Flush with three reads in flight, then a fresh word read.
      for (int i = 0; i < 3; i++) send(32'h800 + 32'(4 * i), 1'b1, 32'h0, 2);
      idle_cyc(2, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 1'b1, 1'b0, 32'h0, acc);
      send(32'h900, 1'b1, 32'h0, 2);
      drain();
      chk("flush_idle", {31'h0, idle}, 32'd1);

      // Misaligned word read is forced to the word address.
      send(32'h102, 1'b1, 32'h0, 2);
      chk("misalign_addr", bus_addr, 32'h100);
      drain();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bit fl;
         fl = ($urandom_range(0, 99) < 3);
         cycle(!fl && ($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 1)), $urandom,
               int'($urandom_range(0, 3)), ($urandom_range(0, 99) < 70), fl,
               ($urandom_range(0, 99) < 40), $urandom, acc);
      end
      drain();
      chk("final_idle", {31'h0, idle}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
